// File: rtl/pong_pkg.sv
// Shared types and constants for the pong ball/game-flow logic.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        SCORED    = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam int EDGE_BOTTOM = 0;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_LEFT   = 3;

    localparam int COL_RX = 0;
    localparam int COL_LX = 1;
    localparam int COL_RY = 2;
    localparam int COL_LY = 5;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/pong_score_counter.sv
// 4-bit score counter that saturates at MAX; clr has priority over inc.
module pong_score_counter #(
    parameter int MAX = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       clr_i,
    output logic [3:0] cnt_o,
    output logic       at_max_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (clr_i) begin
            cnt_q <= 4'd0;
        end else if (inc_i && cnt_q != 4'(MAX)) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign cnt_o    = cnt_q;
    assign at_max_o = (cnt_q == 4'(MAX));

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball kinematics and game-flow FSM; all updates happen on frame_tick cycles,
// and its offsets/velocities feed back into the edge/collision detector.
module ball_motion_ctrl
    import pong_pkg::*;
#(
    parameter int SPEED_X     = 2,
    parameter int SPEED_Y     = 2,
    parameter int SERVE_DELAY = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        serve_btn,
    input  logic [3:0]  ball_detect_edge,
    input  logic [7:0]  collision_detect,
    output logic [31:0] ball_off_x,
    output logic [31:0] ball_off_y,
    output logic [31:0] ball_vel_x,
    output logic [31:0] ball_vel_y,
    output logic [3:0]  score_L,
    output logic [3:0]  score_R,
    output logic [2:0]  game_state,
    output logic        point_pulse
);

    localparam int CW = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
    localparam logic signed [31:0] SX = 32'(SPEED_X);
    localparam logic signed [31:0] SY = 32'(SPEED_Y);

    game_state_t        state_q;
    logic [CW-1:0]      cnt_q;
    logic signed [31:0] off_x_q, off_y_q, vel_x_q, vel_y_q;
    logic signed [31:0] vel_x_d, vel_y_d;
    logic               serve_dir_q, vy_dir_q, point_q;
    logic               r_hit, l_hit, miss_l, miss_r;
    logic               l_at_max, r_at_max;
    logic               inc_l, inc_r, clr_scores;
    logic               unused_col;

    assign unused_col = ^{collision_detect[7:6], collision_detect[4:3]};

    // Paddle hits outrank walls; y bounce is resolved independently of x.
    always_comb begin
        r_hit   = collision_detect[COL_RX] & collision_detect[COL_RY] & (vel_x_q > 0);
        l_hit   = collision_detect[COL_LX] & collision_detect[COL_LY] & (vel_x_q < 0);
        miss_l  = !r_hit && !l_hit && !ball_detect_edge[EDGE_LEFT];
        miss_r  = !r_hit && !l_hit && ball_detect_edge[EDGE_LEFT] && !ball_detect_edge[EDGE_RIGHT];
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        if (r_hit)      vel_x_d = -SX;
        else if (l_hit) vel_x_d = SX;
        if (!ball_detect_edge[EDGE_TOP] && ball_detect_edge[EDGE_BOTTOM] && vel_y_q < 0)
            vel_y_d = SY;
        else if (!ball_detect_edge[EDGE_BOTTOM] && ball_detect_edge[EDGE_TOP] && vel_y_q > 0)
            vel_y_d = -SY;
    end

    assign inc_r      = frame_tick && state_q == PLAY && miss_l;
    assign inc_l      = frame_tick && state_q == PLAY && miss_r;
    assign clr_scores = frame_tick && state_q == GAME_OVER && serve_btn;

    pong_score_counter #(.MAX(WIN_SCORE)) u_score_l (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_l), .clr_i(clr_scores),
        .cnt_o(score_L), .at_max_o(l_at_max)
    );

    pong_score_counter #(.MAX(WIN_SCORE)) u_score_r (
        .clk(clk), .rst_n(rst_n), .inc_i(inc_r), .clr_i(clr_scores),
        .cnt_o(score_R), .at_max_o(r_at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            vel_x_q     <= '0;
            vel_y_q     <= '0;
            serve_dir_q <= 1'b1;
            vy_dir_q    <= 1'b1;
            point_q     <= 1'b0;
        end else begin
            point_q <= 1'b0;
            if (frame_tick) begin
                case (state_q)
                    IDLE: if (serve_btn) begin
                        state_q <= SERVE;
                        cnt_q   <= CW'(SERVE_DELAY);
                    end
                    SERVE: if (cnt_q == '0) begin
                        state_q  <= PLAY;
                        vel_x_q  <= serve_dir_q ? SX : -SX;
                        vel_y_q  <= vy_dir_q ? SY : -SY;
                        vy_dir_q <= ~vy_dir_q;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                    PLAY: if (miss_l || miss_r) begin
                        state_q     <= SCORED;
                        serve_dir_q <= miss_r;
                        point_q     <= 1'b1;
                        off_x_q     <= '0;
                        off_y_q     <= '0;
                        vel_x_q     <= '0;
                        vel_y_q     <= '0;
                    end else begin
                        vel_x_q <= vel_x_d;
                        vel_y_q <= vel_y_d;
                        off_x_q <= off_x_q + vel_x_d;
                        off_y_q <= off_y_q + vel_y_d;
                    end
                    SCORED: if (l_at_max || r_at_max) begin
                        state_q <= GAME_OVER;
                    end else begin
                        state_q <= SERVE;
                        cnt_q   <= CW'(SERVE_DELAY);
                    end
                    GAME_OVER: if (serve_btn) begin
                        state_q     <= SERVE;
                        cnt_q       <= CW'(SERVE_DELAY);
                        serve_dir_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign ball_off_x  = off_x_q;
    assign ball_off_y  = off_y_q;
    assign ball_vel_x  = vel_x_q;
    assign ball_vel_y  = vel_y_q;
    assign game_state  = state_q;
    assign point_pulse = point_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench: each stimulus cycle queues its expected post-edge outputs,
// and a negedge monitor pops and compares them.
module tb_ball_motion_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic [31:0] ox, oy, vx, vy;
        logic [3:0]  sl, sr;
        logic        pp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        serve_btn = 1'b0;
    logic [3:0]  ball_detect_edge = 4'hF;
    logic [7:0]  collision_detect = 8'h00;
    logic [31:0] ball_off_x, ball_off_y, ball_vel_x, ball_vel_y;
    logic [3:0]  score_L, score_R;
    logic [2:0]  game_state;
    logic        point_pulse;

    int checks = 0;
    int errors = 0;
    exp_t  exp_q[$];
    string name_q[$];

    ball_motion_ctrl #(.SPEED_X(2), .SPEED_Y(2), .SERVE_DELAY(3), .WIN_SCORE(2)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve_btn(serve_btn),
        .ball_detect_edge(ball_detect_edge), .collision_detect(collision_detect),
        .ball_off_x(ball_off_x), .ball_off_y(ball_off_y),
        .ball_vel_x(ball_vel_x), .ball_vel_y(ball_vel_y),
        .score_L(score_L), .score_R(score_R),
        .game_state(game_state), .point_pulse(point_pulse)
    );

    always #5 clk = ~clk;

    function automatic exp_t E(input int s, input int ox, input int oy, input int vx,
                               input int vy, input int sl, input int sr, input int pp);
        exp_t e;
        e.st = 3'(s);  e.ox = 32'(ox); e.oy = 32'(oy);
        e.vx = 32'(vx); e.vy = 32'(vy);
        e.sl = 4'(sl); e.sr = 4'(sr); e.pp = 1'(pp);
        return e;
    endfunction

    task automatic cmp(input string nm, input exp_t e);
        exp_t a;
        a = '{game_state, ball_off_x, ball_off_y, ball_vel_x, ball_vel_y, score_L, score_R, point_pulse};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%0d ox=%0d oy=%0d vx=%0d vy=%0d L=%0d R=%0d pp=%0d, required st=%0d ox=%0d oy=%0d vx=%0d vy=%0d L=%0d R=%0d pp=%0d",
                nm, a.st, $signed(a.ox), $signed(a.oy), $signed(a.vx), $signed(a.vy), a.sl, a.sr, a.pp,
                e.st, $signed(e.ox), $signed(e.oy), $signed(e.vx), $signed(e.vy), e.sl, e.sr, e.pp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) cmp(name_q.pop_front(), exp_q.pop_front());
    end

    // One clock cycle of stimulus; expectation describes outputs after its edge.
    task automatic step(input logic t, input logic [3:0] ed, input logic [7:0] co,
                        input logic b, input string nm, input exp_t e);
        #1;
        frame_tick = t; ball_detect_edge = ed; collision_detect = co; serve_btn = b;
        @(posedge clk);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic serve_wait(input int sl, input int sr);
        for (int i = 0; i < 3; i++) step(1, 4'hF, 8'h00, 0, "serve_count", E(1, 0, 0, 0, 0, sl, sr, 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        #12;
        cmp("reset_state", E(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        step(0, 4'hF, 8'h00, 1, "idle_no_tick",  E(0, 0, 0, 0, 0, 0, 0, 0));
        step(1, 4'hF, 8'h00, 1, "serve_entry",   E(1, 0, 0, 0, 0, 0, 0, 0));
        serve_wait(0, 0);
        step(1, 4'hF, 8'h00, 0, "launch1",       E(2, 0, 0, 2, 2, 0, 0, 0));
        step(1, 4'hF, 8'h00, 0, "first_move",    E(2, 2, 2, 2, 2, 0, 0, 0));
        step(1, 4'hE, 8'h00, 0, "bottom_bounce", E(2, 4, 0, 2, -2, 0, 0, 0));
        step(1, 4'hB, 8'h00, 0, "top_bounce",    E(2, 6, 2, 2, 2, 0, 0, 0));
        step(1, 4'hB, 8'h00, 0, "top_hold",      E(2, 8, 4, 2, 2, 0, 0, 0));
        step(1, 4'hD, 8'h05, 0, "rpaddle_wall",  E(2, 6, 6, -2, 2, 0, 0, 0));
        step(1, 4'h7, 8'h22, 0, "lpaddle_wall",  E(2, 8, 8, 2, 2, 0, 0, 0));
        step(0, 4'hD, 8'h00, 0, "no_tick_hold",  E(2, 8, 8, 2, 2, 0, 0, 0));
        step(1, 4'hD, 8'h00, 0, "right_wall",    E(3, 0, 0, 0, 0, 1, 0, 1));
        step(0, 4'hF, 8'h00, 0, "pulse_clear",   E(3, 0, 0, 0, 0, 1, 0, 0));
        step(1, 4'hF, 8'h00, 1, "to_serve",      E(1, 0, 0, 0, 0, 1, 0, 0));
        serve_wait(1, 0);
        step(1, 4'hF, 8'h00, 0, "launch2",       E(2, 0, 0, 2, -2, 1, 0, 0));
        step(1, 4'h5, 8'h00, 0, "both_walls",    E(3, 0, 0, 0, 0, 1, 1, 1));
        step(1, 4'hF, 8'h00, 0, "to_serve2",     E(1, 0, 0, 0, 0, 1, 1, 0));
        serve_wait(1, 1);
        step(1, 4'hF, 8'h00, 0, "launch3",       E(2, 0, 0, -2, 2, 1, 1, 0));
        step(1, 4'h7, 8'h00, 0, "left_wall",     E(3, 0, 0, 0, 0, 1, 2, 1));
        step(1, 4'hF, 8'h00, 0, "game_over",     E(4, 0, 0, 0, 0, 1, 2, 0));
        for (int i = 0; i < 10; i++)
            step(1, (i % 2) ? 4'h0 : 4'hF, 8'hFF, 0, "frozen", E(4, 0, 0, 0, 0, 1, 2, 0));
        step(1, 4'hF, 8'h00, 1, "restart",       E(1, 0, 0, 0, 0, 0, 0, 0));
        serve_wait(0, 0);
        step(1, 4'hF, 8'h00, 0, "launch4",       E(2, 0, 0, 2, -2, 0, 0, 0));
        step(1, 4'hA, 8'h00, 1, "y_both_low",    E(2, 2, -2, 2, -2, 0, 0, 0));

        #1;
        frame_tick = 1'b0; serve_btn = 1'b0; ball_detect_edge = 4'hF; collision_detect = 8'h00;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 cmp("async_reset", E(0, 0, 0, 0, 0, 0, 0, 0));
        #20;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
